// File: rtl/hls_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hls_ctrl_pkg
// Shared types and defaults for the HLS kernel launch controllers.
//   - hls_state_e  : launcher FSM state encoding (3-bit)
//   - HLS_DATA_W   : default kernel return-value width
//   - HLS_CNT_W    : default cycle-counter width
//   - hls_result_t : result bundle {data, timeout, cycles} at the default widths,
//                    for wrappers that move a whole result as one word
// -----------------------------------------------------------------------------
package hls_ctrl_pkg;

    localparam int HLS_DATA_W = 32;
    localparam int HLS_CNT_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_KRST   = 3'd1,
        ST_START  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_RESULT = 3'd4
    } hls_state_e;

    typedef struct packed {
        logic [HLS_DATA_W-1:0] data;
        logic                  timeout;
        logic [HLS_CNT_W-1:0]  cycles;
    } hls_result_t;

endpackage

// File: rtl/hls_watchdog_counter.sv
// -----------------------------------------------------------------------------
// hls_watchdog_counter
// Cycle counter with clear/enable and a fixed threshold compare.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   clear_i     : force the count to 0 (wins over enable)
//   enable_i    : count one cycle
//   count_o     : current count
//   expired_o   : the cycle being counted now is cycle number THRESHOLD,
//                 i.e. count_o + 1 == THRESHOLD
// The count stops at THRESHOLD-1, so it can never wrap.
// -----------------------------------------------------------------------------
module hls_watchdog_counter
    import hls_ctrl_pkg::*;
#(
    parameter int CNT_W     = HLS_CNT_W,
    parameter int THRESHOLD = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             enable_i,
    output logic [CNT_W-1:0] count_o,
    output logic             expired_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(THRESHOLD - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && !expired_o) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o   = count_q;
    assign expired_o = (count_q == LAST);

endmodule

// File: rtl/hls_kernel_launcher.sv
// -----------------------------------------------------------------------------
// hls_kernel_launcher
// Launch controller wrapped around an HLS-generated kernel: takes a run command,
// pulses the kernel reset then start, waits for finished under a watchdog and
// returns {return value, timeout flag, cycle count} on a valid/ready port.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   cmd_valid/ready   : run request handshake (ready only in IDLE)
//   k_reset, k_start  : kernel reset level / one-cycle start pulse
//   k_finished        : kernel done flag (sticky until kernel reset)
//   k_return_val      : kernel return value
//   res_valid/ready   : result handshake
//   res_data          : captured return value, 0 on timeout
//   res_timeout       : run aborted by the watchdog
//   res_cycles        : WAIT cycles up to and including the finished cycle
//   busy              : launcher is not in IDLE
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module hls_kernel_launcher
    import hls_ctrl_pkg::*;
#(
    parameter int DATA_W         = HLS_DATA_W,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = HLS_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    output logic              k_reset,
    output logic              k_start,
    input  logic              k_finished,
    input  logic [DATA_W-1:0] k_return_val,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_timeout,
    output logic [CNT_W-1:0]  res_cycles,
    output logic              busy
);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              timeout;
        logic [CNT_W-1:0]  cycles;
    } result_t;

    hls_state_e       state_q;
    logic             cmd_ready_q;
    logic             k_reset_q;
    logic             k_start_q;
    logic             res_valid_q;
    logic             busy_q;
    result_t          res_q;

    logic [CNT_W-1:0] count;
    logic             expired;

    // Counter is zeroed during START so the first WAIT cycle sees count 0.
    hls_watchdog_counter #(
        .CNT_W     (CNT_W),
        .THRESHOLD (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (state_q == ST_START),
        .enable_i  (state_q == ST_WAIT),
        .count_o   (count),
        .expired_o (expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b0;
            k_reset_q   <= 1'b1;    // kernel held in reset alongside the launcher
            k_start_q   <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            res_q       <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    k_reset_q   <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    // cmd_ready_q gates acceptance so the post-reset cycle
                    // (ready still low) cannot take a command.
                    if (cmd_valid && cmd_ready_q) begin
                        state_q     <= ST_KRST;
                        cmd_ready_q <= 1'b0;
                        k_reset_q   <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                ST_KRST: begin
                    state_q   <= ST_START;
                    k_reset_q <= 1'b0;
                    k_start_q <= 1'b1;
                end
                ST_START: begin
                    state_q   <= ST_WAIT;
                    k_start_q <= 1'b0;
                end
                ST_WAIT: begin
                    // finished beats the watchdog when both land on one cycle
                    if (k_finished) begin
                        res_q.data    <= k_return_val;
                        res_q.timeout <= 1'b0;
                        res_q.cycles  <= count + CNT_W'(1);
                        res_valid_q   <= 1'b1;
                        state_q       <= ST_RESULT;
                    end else if (expired) begin
                        res_q.data    <= '0;
                        res_q.timeout <= 1'b1;
                        res_q.cycles  <= CNT_W'(TIMEOUT_CYCLES);
                        res_valid_q   <= 1'b1;
                        state_q       <= ST_RESULT;
                    end
                end
                ST_RESULT: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    cmd_ready_q <= 1'b0;
                    k_reset_q   <= 1'b1;
                    k_start_q   <= 1'b0;
                    res_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign k_reset     = k_reset_q;
    assign k_start     = k_start_q;
    assign res_valid   = res_valid_q;
    assign res_data    = res_q.data;
    assign res_timeout = res_q.timeout;
    assign res_cycles  = res_q.cycles;
    assign busy        = busy_q;

endmodule

// File: tb/tb_hls_kernel_launcher.sv
module tb_hls_kernel_launcher;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        res_ready = 1'b1;
    logic        cmd_ready, k_reset, k_start, k_finished, res_valid, res_timeout, busy;
    logic [31:0] k_return_val, res_data;
    logic [15:0] res_cycles;

    hls_kernel_launcher #(
        .DATA_W         (32),
        .TIMEOUT_CYCLES (T),
        .CNT_W          (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .k_reset      (k_reset),
        .k_start      (k_start),
        .k_finished   (k_finished),
        .k_return_val (k_return_val),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_timeout  (res_timeout),
        .res_cycles   (res_cycles),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Behavioural kernel: finished rises kern_f cycles after the start cycle and
    // stays high until k_reset. kern_f == 0 means it never finishes.
    logic        fin = 1'b0;
    int          kt = 0;
    int          kern_f = 0;
    logic [31:0] kern_rv = '0;
    logic        stale = 1'b0;

    always @(posedge clk) begin
        if (k_reset === 1'b1) begin
            fin <= 1'b0;
            kt  <= 0;
        end else if (k_start === 1'b1) begin
            kt  <= 1;
            fin <= (kern_f == 1);
        end else if (kt != 0) begin
            kt <= kt + 1;
            if (kt + 1 == kern_f) fin <= 1'b1;
        end
    end

    assign k_finished   = fin | stale;
    assign k_return_val = fin ? kern_rv : 32'hBADBAD00;

    typedef struct {
        logic [31:0] data;
        logic        to;
        logic [15:0] cycles;
        int          at;
    } exp_t;

    exp_t q[$];
    int   hs_cyc = -10;
    logic prev_v = 1'b0;
    bit   rand_rr = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rr) res_ready = ($urandom_range(0, 3) != 0);
    endtask

    // Reference: a kernel finishing f cycles after start succeeds iff f is within
    // the watchdog window; result appears 3 cycles after accept plus WAIT length.
    function automatic exp_t model(input int f, input logic [31:0] rv, input int acc);
        exp_t e;
        if (f >= 1 && f <= T) begin
            e.data = rv; e.to = 1'b0; e.cycles = 16'(f); e.at = acc + 3 + f;
        end else begin
            e.data = '0; e.to = 1'b1; e.cycles = 16'(T); e.at = acc + 3 + T;
        end
        return e;
    endfunction

    task automatic issue(input int f, input logic [31:0] rv, output int acc);
        int w;
        w = 0;
        acc = -1;
        cmd_valid = 1'b1;
        while (cmd_ready !== 1'b1 && w < 300) begin
            tick();
            w++;
        end
        if (cmd_ready !== 1'b1) begin
            chk("cmd_accept_wait", 64'd0, 64'd1);
            cmd_valid = 1'b0;
        end else begin
            acc = cyc;
            kern_f = f;
            kern_rv = rv;
            q.push_back(model(f, rv, acc));
            tick();
            cmd_valid = 1'b0;
            chk("krst_cycle", {k_reset, k_start, busy, cmd_ready}, 4'b1010);
            tick();
            chk("start_cycle", {k_reset, k_start}, 2'b01);
            tick();
            chk("wait_entry", {k_reset, k_start}, 2'b00);
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((q.size() != 0 || res_valid === 1'b1) && w < 400) begin
            tick();
            w++;
        end
        if (w >= 400) chk("drain_wait", 64'd0, 64'd1);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (reset) begin
            prev_v = 1'b0;
        end else begin
            if (res_valid === 1'b1) begin
                if (q.size() == 0) begin
                    chk("unexpected_res_valid", 64'd1, 64'd0);
                end else begin
                    if (!prev_v) chk("res_latency", 64'(cyc), 64'(q[0].at));
                    chk("res_data", res_data, q[0].data);
                    chk("res_timeout", res_timeout, q[0].to);
                    chk("res_cycles", res_cycles, q[0].cycles);
                    chk("result_ready_busy", {cmd_ready, busy}, 2'b01);
                    if (res_ready) begin
                        hs_cyc = cyc;
                        void'(q.pop_front());
                    end
                end
            end
            prev_v = res_valid;
        end
    end

    initial begin
        int acc, acc2, w;

        // reset values
        reset = 1'b1;
        tick();
        tick();
        chk("rst_ctrl", {cmd_ready, k_reset, k_start, res_valid, res_timeout, busy}, 6'b010000);
        chk("rst_data", res_data, 32'd0);
        chk("rst_cycles", res_cycles, 16'd0);
        reset = 1'b0;
        tick();
        chk("post_rst", {cmd_ready, k_reset, busy}, 3'b100);
        repeat (5) tick();

        // single run, then timeout, then finish exactly on / one past the threshold
        issue(6, 32'd6, acc);
        drain();
        issue(0, 32'h1234, acc);
        drain();
        issue(T, 32'hDEADBEEF, acc);
        drain();
        issue(T + 1, 32'h0BAD_F00D, acc);
        drain();

        // backpressure with cmd_valid held, then back-to-back run
        res_ready = 1'b0;
        issue(6, 32'd6, acc);
        cmd_valid = 1'b1;
        w = 0;
        while (res_valid !== 1'b1 && w < 50) begin
            tick();
            w++;
        end
        chk("bp_result_seen", res_valid, 1'b1);
        repeat (5) tick();
        chk("bp_no_accept", {cmd_ready, res_valid}, 2'b01);
        res_ready = 1'b1;
        issue(6, 32'd6, acc2);
        chk("b2b_idle_gap", 64'(acc2), 64'(hs_cyc + 1));
        drain();

        // stale finished across IDLE/KRST/START must not be captured
        stale = 1'b1;
        repeat (3) tick();
        issue(5, 32'h0000_A5A5, acc);
        stale = 1'b0;
        drain();

        // reset during WAIT cycle 2
        issue(7, 32'h0000_CAFE, acc);
        tick();
        reset = 1'b1;
        q.delete();
        tick();
        chk("midrst_state", {k_reset, busy, res_valid, cmd_ready, k_start}, 5'b10000);
        reset = 1'b0;
        repeat (20) tick();
        chk("midrst_ready", {cmd_ready, busy, k_reset}, 3'b100);
        issue(3, 32'h0000_0055, acc);
        drain();

        // randomized runs with random result backpressure
        rand_rr = 1'b1;
        for (int i = 0; i < 25; i++) begin
            issue($urandom_range(1, T + 2), $urandom, acc);
            repeat ($urandom_range(0, 3)) tick();
        end
        drain();
        rand_rr = 1'b0;
        res_ready = 1'b1;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
